// File: rtl/arcade_input.sv
// rtl/arcade_input.sv - merges PS/2 keys and joysticks into per-player controls
// with autofire, stretched coin pulses and a shared pause toggle.
module arcade_input #(
  parameter int NUM_PLAYERS     = 2,
  parameter int COIN_CYCLES     = 9600000,
  parameter int AUTOFIRE_CYCLES = 3200000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [10:0]               ps2_key,
  input  logic [NUM_PLAYERS*10-1:0] joystick,
  input  logic [NUM_PLAYERS-1:0]    autofire_en,
  output logic [NUM_PLAYERS*4-1:0]  joy,
  output logic [NUM_PLAYERS*3-1:0]  buttons,
  output logic [NUM_PLAYERS-1:0]    start,
  output logic [NUM_PLAYERS-1:0]    coin,
  output logic                      pause
);

  localparam int CW = $clog2(COIN_CYCLES + 1);
  localparam int AW = $clog2(AUTOFIRE_CYCLES + 1);

  logic       strobe_prev;
  logic       key_evt;
  logic       hit;
  logic [1:0] hit_player;
  logic [3:0] hit_bit;
  logic [8:0] key_state [NUM_PLAYERS];
  logic       pause_any;
  logic       pause_prev;
  logic       unused_ext;

  assign key_evt    = ps2_key[10] != strobe_prev;
  assign unused_ext = ps2_key[8];

  // hit_bit follows the joystick bit order so keys and sticks merge directly
  always_comb begin
    hit        = 1'b1;
    hit_player = 2'd0;
    hit_bit    = 4'd0;
    case (ps2_key[7:0])
      8'h74: hit_bit = 4'd0;
      8'h6B: hit_bit = 4'd1;
      8'h72: hit_bit = 4'd2;
      8'h75: hit_bit = 4'd3;
      8'h14: hit_bit = 4'd4;
      8'h11: hit_bit = 4'd5;
      8'h29: hit_bit = 4'd6;
      8'h16: hit_bit = 4'd7;
      8'h2E: hit_bit = 4'd8;
      8'h34: begin hit_player = 2'd1; hit_bit = 4'd0; end
      8'h23: begin hit_player = 2'd1; hit_bit = 4'd1; end
      8'h2B: begin hit_player = 2'd1; hit_bit = 4'd2; end
      8'h2D: begin hit_player = 2'd1; hit_bit = 4'd3; end
      8'h1C: begin hit_player = 2'd1; hit_bit = 4'd4; end
      8'h1B: begin hit_player = 2'd1; hit_bit = 4'd5; end
      8'h15: begin hit_player = 2'd1; hit_bit = 4'd6; end
      8'h1E: begin hit_player = 2'd1; hit_bit = 4'd7; end
      8'h36: begin hit_player = 2'd1; hit_bit = 4'd8; end
      default: hit = 1'b0;
    endcase
    if (int'(hit_player) >= NUM_PLAYERS) hit = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_prev <= 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) key_state[p] <= '0;
    end else begin
      strobe_prev <= ps2_key[10];
      if (key_evt && hit) begin
        for (int p = 0; p < NUM_PLAYERS; p++)
          if (int'(hit_player) == p) key_state[p][hit_bit] <= ps2_key[9];
      end
    end
  end

  always_comb begin
    pause_any = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) pause_any = pause_any | joystick[p*10+9];
  end

  // Edge detectors come out of reset "high" so a held input needs a fresh rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pause_prev <= 1'b1;
      pause      <= 1'b0;
    end else begin
      pause_prev <= pause_any;
      if (pause_any && !pause_prev) pause <= ~pause;
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [8:0]    raw;
    logic          af_run;
    logic [3:0]    joy_q;
    logic [1:0]    btn_q;
    logic          start_q;
    logic          fire_q;
    logic          phase;
    logic [AW-1:0] af_cnt;
    logic          coin_prev;
    logic [CW-1:0] coin_cnt;

    assign raw    = key_state[p] | joystick[p*10 +: 9];
    assign af_run = raw[4] & autofire_en[p];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        joy_q     <= '0;
        btn_q     <= '0;
        start_q   <= 1'b0;
        fire_q    <= 1'b0;
        phase     <= 1'b0;
        af_cnt    <= '0;
        coin_prev <= 1'b1;
        coin_cnt  <= '0;
      end else begin
        joy_q   <= {raw[3], raw[2], raw[0], raw[1]};
        btn_q   <= {raw[6], raw[5]};
        start_q <= raw[7];
        // phase flips after each full half-period; output is its inverse so a press starts high
        if (af_run) begin
          fire_q <= ~phase;
          if (af_cnt == AW'(AUTOFIRE_CYCLES - 1)) begin
            af_cnt <= '0;
            phase  <= ~phase;
          end else begin
            af_cnt <= af_cnt + AW'(1);
          end
        end else begin
          fire_q <= raw[4];
          af_cnt <= '0;
          phase  <= 1'b0;
        end
        coin_prev <= raw[8];
        if (coin_cnt != '0) coin_cnt <= coin_cnt - CW'(1);
        else if (raw[8] && !coin_prev) coin_cnt <= CW'(COIN_CYCLES);
      end
    end

    assign joy[p*4 +: 4]     = joy_q;
    assign buttons[p*3 +: 3] = {btn_q, fire_q};
    assign start[p]          = start_q;
    assign coin[p]           = coin_cnt != '0;
  end

endmodule

// File: tb/tb_arcade_input.sv
// tb/tb_arcade_input.sv - directed self-checking bench for arcade_input
// (two-player instance plus a one-player instance sharing the PS/2 input).
module tb_arcade_input;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] ps2_key = '0;
  logic [19:0] joystick = '0;
  logic [1:0]  autofire_en = '0;
  logic [7:0]  joy;
  logic [5:0]  buttons;
  logic [1:0]  start;
  logic [1:0]  coin;
  logic        pause;

  logic [9:0]  joystick1 = '0;
  logic        autofire_en1 = 1'b0;
  logic [3:0]  joy1;
  logic [2:0]  buttons1;
  logic        start1;
  logic        coin1;
  logic        pause1;

  int errors = 0;
  int checks = 0;

  arcade_input #(.NUM_PLAYERS(2), .COIN_CYCLES(4), .AUTOFIRE_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .ps2_key(ps2_key), .joystick(joystick),
    .autofire_en(autofire_en), .joy(joy), .buttons(buttons), .start(start),
    .coin(coin), .pause(pause)
  );

  arcade_input #(.NUM_PLAYERS(1), .COIN_CYCLES(4), .AUTOFIRE_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .ps2_key(ps2_key), .joystick(joystick1),
    .autofire_en(autofire_en1), .joy(joy1), .buttons(buttons1), .start(start1),
    .coin(coin1), .pause(pause1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [7:0] code, input logic pressed, input logic ext);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({joy, buttons, start, coin, pause} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h expected=0", {joy, buttons, start, coin, pause});
    end
    checks++;
    if ({joy1, buttons1, start1, coin1, pause1} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs_1p got=%h expected=0", {joy1, buttons1, start1, coin1, pause1});
    end
    reset = 1'b0;
    step();
    checks++;
    if ({joy, buttons, start, coin, pause} !== 19'd0) begin
      errors++;
      $display("FAIL after_release got=%h expected=0", {joy, buttons, start, coin, pause});
    end
  endtask

  task automatic test_key();
    send_key(8'h75, 1'b1, 1'b0);
    step();
    checks++;
    if (joy !== 8'h00) begin errors++; $display("FAIL key_latency1 joy=%h expected=00", joy); end
    step();
    checks++;
    if (joy !== 8'h08) begin errors++; $display("FAIL key_up_press joy=%h expected=08", joy); end
    send_key(8'h75, 1'b0, 1'b0);
    step(); step();
    checks++;
    if (joy !== 8'h00) begin errors++; $display("FAIL key_up_release joy=%h expected=00", joy); end
    send_key(8'h2D, 1'b1, 1'b0);
    step(); step();
    checks++;
    if (joy !== 8'h80) begin errors++; $display("FAIL key_p2_up joy=%h expected=80", joy); end
    checks++;
    if (joy1 !== 4'h0) begin errors++; $display("FAIL key_p2_on_1p joy1=%h expected=0", joy1); end
    send_key(8'h2D, 1'b0, 1'b0);
    step(); step();
    send_key(8'h14, 1'b1, 1'b1);
    step(); step();
    checks++;
    if (buttons !== 6'b000001) begin errors++; $display("FAIL key_extended_b1 buttons=%b expected=000001", buttons); end
    send_key(8'h14, 1'b0, 1'b1);
    step(); step();
    send_key(8'h5A, 1'b1, 1'b0);
    step(); step();
    checks++;
    if ({joy, buttons, start, coin} !== 18'd0) begin
      errors++;
      $display("FAIL key_unmapped got=%h expected=0", {joy, buttons, start, coin});
    end
    send_key(8'h16, 1'b1, 1'b0);
    joystick[7] = 1'b1;
    step(); step();
    checks++;
    if (start !== 2'b01) begin errors++; $display("FAIL start_or start=%b expected=01", start); end
    send_key(8'h16, 1'b0, 1'b0);
    step(); step();
    checks++;
    if (start !== 2'b01) begin errors++; $display("FAIL start_joy_holds start=%b expected=01", start); end
    joystick[7] = 1'b0;
    step();
    checks++;
    if (start !== 2'b00) begin errors++; $display("FAIL start_release start=%b expected=00", start); end
  endtask

  task automatic test_joystick_levels();
    joystick[10] = 1'b1;
    joystick[5]  = 1'b1;
    joystick[17] = 1'b1;
    joystick[3]  = 1'b1;
    step();
    checks++;
    if (joy !== 8'h28) begin errors++; $display("FAIL joy_levels joy=%h expected=28", joy); end
    checks++;
    if (buttons !== 6'b000010) begin errors++; $display("FAIL btn_levels buttons=%b expected=000010", buttons); end
    checks++;
    if (start !== 2'b10) begin errors++; $display("FAIL start_levels start=%b expected=10", start); end
    joystick = '0;
    step();
  endtask

  task automatic test_coin();
    joystick[8] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (coin[0] !== (i <= 4)) begin
        errors++;
        $display("FAIL coin_pulse cycle=%0d coin=%b expected=%b", i, coin[0], i <= 4);
      end
    end
    joystick[8] = 1'b0;
    step(); step();
    joystick[8] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (coin[0] !== (i <= 4)) begin
        errors++;
        $display("FAIL coin_retrigger cycle=%0d coin=%b expected=%b", i, coin[0], i <= 4);
      end
      if (i == 2) joystick[8] = 1'b0;
      if (i == 3) joystick[8] = 1'b1;
    end
    joystick[8] = 1'b0;
    step(); step();
  endtask

  task automatic test_autofire();
    logic [11:0] pat;
    pat = 12'b111000111000;
    autofire_en[1] = 1'b1;
    joystick[14] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (buttons[3] !== pat[11-i]) begin
        errors++;
        $display("FAIL autofire cycle=%0d b1=%b expected=%b", i, buttons[3], pat[11-i]);
      end
    end
    joystick[14] = 1'b0;
    step();
    checks++;
    if (buttons[3] !== 1'b0) begin errors++; $display("FAIL autofire_release b1=%b expected=0", buttons[3]); end
    autofire_en[1] = 1'b0;
    joystick[14] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (buttons[3] !== 1'b1) begin
        errors++;
        $display("FAIL autofire_off cycle=%0d b1=%b expected=1", i, buttons[3]);
      end
    end
    joystick[14] = 1'b0;
    step();
  endtask

  task automatic test_pause();
    checks++;
    if (pause !== 1'b0) begin errors++; $display("FAIL pause_initial pause=%b expected=0", pause); end
    joystick[9]  = 1'b1;
    joystick[19] = 1'b1;
    step();
    checks++;
    if (pause !== 1'b1) begin errors++; $display("FAIL pause_toggle_on pause=%b expected=1", pause); end
    step(); step();
    checks++;
    if (pause !== 1'b1) begin errors++; $display("FAIL pause_single_toggle pause=%b expected=1", pause); end
    joystick[9]  = 1'b0;
    joystick[19] = 1'b0;
    step();
    checks++;
    if (pause !== 1'b1) begin errors++; $display("FAIL pause_on_release pause=%b expected=1", pause); end
    joystick[19] = 1'b1;
    step();
    checks++;
    if (pause !== 1'b0) begin errors++; $display("FAIL pause_toggle_off pause=%b expected=0", pause); end
    joystick[19] = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_coin();
    int highs;
    joystick[8] = 1'b1;
    joystick[0] = 1'b1;
    step();
    checks++;
    if (coin[0] !== 1'b1) begin errors++; $display("FAIL coin_before_reset coin=%b expected=1", coin[0]); end
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (coin[0] !== 1'b0) begin errors++; $display("FAIL coin_async_reset coin=%b expected=0", coin[0]); end
    checks++;
    if (joy !== 8'h00) begin errors++; $display("FAIL joy_async_reset joy=%h expected=00", joy); end
    step();
    reset = 1'b0;
    step();
    checks++;
    if (joy !== 8'h02) begin errors++; $display("FAIL joy_after_reset joy=%h expected=02", joy); end
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      if (coin[0] !== 1'b0) highs++;
      step();
    end
    checks++;
    if (highs !== 0) begin errors++; $display("FAIL coin_held_after_reset high_cycles=%0d expected=0", highs); end
    checks++;
    if (pause !== 1'b0) begin errors++; $display("FAIL pause_after_reset pause=%b expected=0", pause); end
    joystick = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_key();
    test_joystick_levels();
    test_coin();
    test_autofire();
    test_pause();
    test_reset_mid_coin();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
